// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, fetches from the instruction port, and buffers {pc, instr} in an in-order queue.
// Latency: a fetched word is visible at the decode interface one edge after its address is presented.
// Backpressure: when the queue is full and decode does not pop, fetch_pc holds; a full queue still pushes in a cycle where it pops.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inst_addr / instr   instruction port address (== fetch_pc) and same-cycle returned word
//   redirect_valid/_pc  taken branch/jump: flush the queue and restart at redirect_pc
//   id_valid/id_ready   decode handshake; id_instr, id_pc, id_pc_plus4 describe the queue head
//   fetch_fault/fault_pc sticky fault on an illegal fetch address, and the offending address
//   occupancy           number of queued entries
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] INST_BASE  = 32'h0000_3000,
  parameter logic [31:0] INST_LIMIT = 32'h0000_3FFC,
  parameter int          DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              inst_addr,
  input  logic [31:0]              instr,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc_plus4,
  output logic                     fetch_fault,
  output logic [31:0]              fault_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_pc_q, fault_pc_d;

  logic legal;
  logic pop;
  logic push;
  logic fault_set;

  assign legal = (fetch_pc_q[1:0] == 2'b00) &&
                 (fetch_pc_q >= INST_BASE) &&
                 (fetch_pc_q <= INST_LIMIT);

  assign pop  = id_valid && id_ready;
  // A pop in the same cycle frees the slot, so a full queue can still push.
  assign push = !redirect_valid && !fault_q && legal &&
                ((count_q < DEPTH_C) || pop);
  assign fault_set = !redirect_valid && !fault_q && !legal;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    if (redirect_valid) begin
      // A pop accepted in this cycle is simply discarded with the rest of the queue.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      fault_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (fault_set) begin
        fault_d    = 1'b1;
        fault_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        instr_mem_q[wr_ptr_q] <= instr;
      end
    end
  end

  assign inst_addr   = fetch_pc_q;
  assign id_valid    = (count_q != '0);
  assign id_instr    = instr_mem_q[rd_ptr_q];
  assign id_pc       = pc_mem_q[rd_ptr_q];
  assign id_pc_plus4 = pc_mem_q[rd_ptr_q] + 32'd4;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;
  assign occupancy   = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios followed by random traffic, compared against a queue-based model.
// Latency: checks at each falling edge the state produced by the preceding rising edge.
// Backpressure: id_ready is driven directly (held low, high, or random) to exercise full-queue behaviour.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_addr;
  logic [31:0] instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [2:0]  occupancy;

  inst_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .instr(instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault),
    .fault_pc(fault_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory: word-indexed, combinational read.
  logic [31:0] mem [0:4095];
  assign instr = mem[inst_addr[13:2]];

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of fetched words plus the fetch PC and fault state.
  logic [31:0] m_qpc [$];
  logic [31:0] m_qins [$];
  logic [31:0] m_pc;
  bit          m_fault;
  logic [31:0] m_fpc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_qpc.delete();
    m_qins.delete();
    m_pc    = 32'h3000;
    m_fault = 0;
    m_fpc   = 32'h0;
  endtask

  task automatic check_outputs();
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_qpc.size() != 0});
    chk("occupancy", 32'(occupancy), 32'(m_qpc.size()));
    chk("inst_addr", inst_addr, m_pc);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("fault_pc", fault_pc, m_fpc);
    if (m_qpc.size() != 0) begin
      chk("id_pc", id_pc, m_qpc[0]);
      chk("id_instr", id_instr, m_qins[0]);
      chk("id_pc_plus4", id_pc_plus4, m_qpc[0] + 32'd4);
    end
  endtask

  // Called at a falling edge: check, drive inputs, advance the model, move to the next falling edge.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop;
    bit legal;
    check_outputs();
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    pop   = (m_qpc.size() != 0) && rdy;
    legal = (m_pc % 4 == 0) && (m_pc >= 32'h3000) && (m_pc <= 32'h3FFC);
    if (rv) begin
      m_qpc.delete();
      m_qins.delete();
      m_pc    = rpc;
      m_fault = 0;
    end else begin
      if (pop) begin
        void'(m_qpc.pop_front());
        void'(m_qins.pop_front());
      end
      if (!m_fault) begin
        if (!legal) begin
          m_fault = 1;
          m_fpc   = m_pc;
        end else if (m_qpc.size() < 4) begin
          m_qpc.push_back(m_pc);
          m_qins.push_back(mem[m_pc[13:2]]);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0, 1:    return 32'h3000 + 32'($urandom_range(0, 63)) * 4;
      2:       return 32'h3FF0 + 32'($urandom_range(0, 3)) * 4;
      3:       return 32'h3000 + 32'($urandom_range(0, 255));
      4:       return 32'h2FFC;
      default: return 32'h4000;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    model_reset();

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst_addr", inst_addr, 32'h3000);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd4);
    rst_n = 1'b1;

    // Stream with decode always ready.
    for (int i = 0; i < 8; i++) step(0, 0, 1);

    // Backpressure from a fresh start at 0x3000, then drain.
    step(1, 32'h3000, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    chk("bp_occupancy", 32'(occupancy), 32'd4);
    chk("bp_inst_addr", inst_addr, 32'h3010);
    for (int i = 0; i < 6; i++) step(0, 0, 1);

    // Redirect while full.
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    step(1, 32'h3040, 1);
    chk("redir_empty", {31'd0, id_valid}, 32'd0);
    step(0, 0, 0);
    chk("redir_head", id_pc, 32'h3040);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // End of instruction range, then recovery.
    step(1, 32'h3FF8, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    chk("eor_fault_pc", fault_pc, 32'h4000);
    step(1, 32'h3000, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Misaligned redirect.
    step(1, 32'h3002, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("mis_fault_pc", fault_pc, 32'h3002);

    // Asynchronous reset between edges with three entries queued.
    step(1, 32'h3000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("ar_pre_occ", 32'(occupancy), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit rv;
      rv = ($urandom_range(0, 15) == 0);
      step(rv, rv ? rand_target() : 32'h0, $urandom_range(0, 2) != 0);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
